stage_mm: RTL and testbench
===========================

// Module: stage_mm
// PURPOSE
//  Memory-access pipeline stage between STAGE_EX and STAGE_WB.
//  - Consumes the EX pipeline registers and performs word loads/stores over a req/ack data-memory port.
//  - Stalls the upstream pipeline while an access is outstanding.
//  - Registers the result towards WB; the same registers drive the ffw_MM_* forwarding inputs of STAGE_EX.
// PARAMETERS
//  DATA_W       `DATA_W (32)      datapath / memory word width
//  DATA_ADDR_W  `DATA_ADDR_W (32) byte address width
//  REG_ADDR_W   `REG_ADDR_W (5)   register index width
// PORTS
//  clk              in   1            clock, all state on posedge
//  rst_n            in   1            asynchronous, active-low reset
//  en               in   1            stage enable, same meaning as in other stages
//  in_flush         in   1            EX out_flush: slot is a bubble
//  in_reg_wr        in   1            EX out_reg_wr
//  in_reg_addr_rd   in   REG_ADDR_W   EX out_reg_addr_rd
//  in_reg_data_rd   in   DATA_W       EX out_reg_data_rd (ALU result, or store data when in_is_store)
//  in_mem_addr      in   DATA_ADDR_W  EX out_alu_mem_addr
//  in_is_load       in   1            EX out_is_load
//  in_is_store      in   1            EX out_is_store
//  mem_req          out  1            access request, held until mem_ack
//  mem_we           out  1            1 = store, 0 = load
//  mem_addr         out  DATA_ADDR_W  word-aligned byte address
//  mem_wdata        out  DATA_W       store data
//  mem_ack          in   1            access complete this cycle; mem_rdata valid for loads
//  mem_rdata        in   DATA_W       load data
//  stall            out  1            combinational, to IF/ID/EX stall inputs
//  misaligned       out  1            registered 1-cycle pulse: op suppressed, in_mem_addr[1:0]!=0
//  out_reg_wr       out  1            to WB and to EX ffw_MM_reg_wr
//  out_reg_addr_rd  out  REG_ADDR_W   to WB and to EX ffw_MM_reg_addr_rd
//  out_reg_data_rd  out  DATA_W       to WB and to EX ffw_MM_reg_data_rd
//  out_flush        out  1            bubble marker to WB
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; mem_req=0; out_reg_wr=0; out_flush=1; misaligned=0.
//    out_reg_addr_rd=0 and out_reg_data_rd=0. An access in flight is abandoned and mem_req drops immediately.
//  - Valid op: mem_op = en & !in_flush & (in_is_load | in_is_store) & (in_mem_addr[1:0]==0).
//  - FSM IDLE:
//    - mem_op: mem_req=1 combinationally.
//    - mem_ack in the same cycle: completes with zero wait, stays IDLE.
//    - otherwise -> WAIT.
//  - FSM WAIT: mem_req=1 with mem_we/mem_addr/mem_wdata stable; -> IDLE on mem_ack.
//    Inputs are stable because upstream is stalled.
//  - stall = mem_req & !mem_ack (IDLE or WAIT).
//  - Latency: 0 wait states -> result registered at the next edge; N wait states -> N extra cycles.
//  - Output register updates when en & !stall:
//    - out_reg_wr <= in_reg_wr & !in_flush & !misalign_now; out_flush <= in_flush.
//    - out_reg_data_rd <= in_is_load ? mem_rdata : in_reg_data_rd; out_reg_addr_rd <= in_reg_addr_rd.
//    - A store never writes a register (EX already clears reg_wr); do not rely on that, gate with !in_is_store.
//  - While stall=1: output regs load a bubble: out_reg_wr=0, out_flush=1. WB never sees duplicates.
//  - Misaligned load/store (not flushed): no mem_req; misaligned pulses 1 cycle; out_reg_wr=0.
//  - en=0: no request issued; FSM in WAIT still completes (holds req until ack); outputs hold.
//  - mem_ack while IDLE without mem_req: ignored.
//  - mem_addr = {in_mem_addr[DATA_ADDR_W-1:2],2'b00}; mem_wdata = in_reg_data_rd; mem_we = in_is_store.
// STRUCTURE
//  - defines.vh gains `MM_ST_IDLE/`MM_ST_WAIT and `MM_STATE_W; width macros reused from it.
//  - Sub-module: mm_mem_if (2-state req/ack FSM, stall gen); stage_mm holds the pipeline registers.
// TESTING
//  1. rst_n=0 mid-WAIT -> mem_req=0 same cycle, out_flush=1, out_reg_wr=0, state IDLE.
//  2. Load addr 0x100, ack with 0 wait, rdata 0xDEADBEEF, rd=5 -> next edge out_reg_wr=1, rd=5,
//     data 0xDEADBEEF; stall never 1.
//  3. Store addr 0x204, data 0x12345678, ack after 3 cycles -> mem_we=1 for 4 cycles, stall=1 for 3,
//     args stable; out_reg_wr=0 throughout.
//  4. ALU op rd=7, data 0x55, no mem op -> no mem_req; next edge out_reg_wr=1, out_reg_data_rd=0x55.
//  5. Load addr 0x102 -> no mem_req, misaligned=1 for one cycle, out_reg_wr=0.
//  6. in_flush=1 with in_is_load=1 -> no mem_req, out_flush=1, out_reg_wr=0; next valid load proceeds normally.

Source files
------------

// File: rtl/stage_mm_pkg.sv
// ============================================================================
//  Module  : stage_mm_pkg
//  Brief   : Shared widths, FSM encoding and helpers for the MM pipeline stage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package stage_mm_pkg;

    localparam int MM_DATA_W      = 32;
    localparam int MM_DATA_ADDR_W = 32;
    localparam int MM_REG_ADDR_W  = 5;
    localparam int MM_STATE_W     = 1;

    typedef enum logic [MM_STATE_W-1:0] {
        MM_ST_IDLE = 1'b0,
        MM_ST_WAIT = 1'b1
    } mm_state_t;

    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stage_mm_if.sv
// ============================================================================
//  Module  : stage_mm_if
//  Brief   : Word-wide req/ack data-memory port between stage_mm and memory.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface stage_mm_if import stage_mm_pkg::*; #(
    parameter int DATA_W      = MM_DATA_W,
    parameter int DATA_ADDR_W = MM_DATA_ADDR_W
) ();

    logic                   mem_req;
    logic                   mem_we;
    logic [DATA_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   mem_ack;
    logic [DATA_W-1:0]      mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/stage_mm_mem_if.sv
// ============================================================================
//  Module  : stage_mm_mem_if
//  Brief   : Two-state req/ack sequencer; raises stall while an access waits.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module stage_mm_mem_if import stage_mm_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_op,
    input  logic mem_ack,
    output logic mem_req,
    output logic stall
);

    mm_state_t r_state;
    mm_state_t w_state_nxt;
    logic      w_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MM_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            MM_ST_IDLE: begin
                if (mem_op) begin
                    w_req = 1'b1;
                    if (!mem_ack) begin
                        w_state_nxt = MM_ST_WAIT;
                    end
                end
            end
            MM_ST_WAIT: begin
                // Request is held even with en low: the access must finish.
                w_req = 1'b1;
                if (mem_ack) begin
                    w_state_nxt = MM_ST_IDLE;
                end
            end
            default: w_state_nxt = MM_ST_IDLE;
        endcase
    end

    // Reset abandons an in-flight access without waiting for a clock edge.
    assign mem_req = w_req & rst_n;
    assign stall   = mem_req & ~mem_ack;

endmodule

`default_nettype wire

// File: rtl/stage_mm.sv
// ============================================================================
//  Module  : stage_mm
//  Brief   : Memory-access stage: word loads/stores over req/ack, MM->WB regs.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module stage_mm import stage_mm_pkg::*; #(
    parameter int DATA_W      = MM_DATA_W,
    parameter int DATA_ADDR_W = MM_DATA_ADDR_W,
    parameter int REG_ADDR_W  = MM_REG_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   in_flush,
    input  logic                   in_reg_wr,
    input  logic [REG_ADDR_W-1:0]  in_reg_addr_rd,
    input  logic [DATA_W-1:0]      in_reg_data_rd,
    input  logic [DATA_ADDR_W-1:0] in_mem_addr,
    input  logic                   in_is_load,
    input  logic                   in_is_store,
    stage_mm_if.master             mem,
    output logic                   stall,
    output logic                   misaligned,
    output logic                   out_reg_wr,
    output logic [REG_ADDR_W-1:0]  out_reg_addr_rd,
    output logic [DATA_W-1:0]      out_reg_data_rd,
    output logic                   out_flush
);

    logic w_mem_access;
    logic w_aligned;
    logic w_mem_op;
    logic w_misalign_now;

    assign w_mem_access   = en & ~in_flush & (in_is_load | in_is_store);
    assign w_aligned      = word_aligned(in_mem_addr[1:0]);
    assign w_mem_op       = w_mem_access & w_aligned;
    assign w_misalign_now = w_mem_access & ~w_aligned;

    stage_mm_mem_if u_mem_if (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem_op  (w_mem_op),
        .mem_ack (mem.mem_ack),
        .mem_req (mem.mem_req),
        .stall   (stall)
    );

    assign mem.mem_we    = in_is_store;
    assign mem.mem_addr  = {in_mem_addr[DATA_ADDR_W-1:2], 2'b00};
    assign mem.mem_wdata = in_reg_data_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned      <= 1'b0;
            out_reg_wr      <= 1'b0;
            out_reg_addr_rd <= '0;
            out_reg_data_rd <= '0;
            out_flush       <= 1'b1;
        end else begin
            misaligned <= w_misalign_now;
            if (stall) begin
                // Bubble each waiting cycle so WB never retires the op twice.
                out_reg_wr <= 1'b0;
                out_flush  <= 1'b1;
            end else if (en) begin
                out_reg_wr      <= in_reg_wr & ~in_flush & ~w_misalign_now & ~in_is_store;
                out_flush       <= in_flush;
                out_reg_addr_rd <= in_reg_addr_rd;
                out_reg_data_rd <= in_is_load ? mem.mem_rdata : in_reg_data_rd;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stage_mm.sv
// ============================================================================
//  Module  : tb_stage_mm
//  Brief   : Directed self-checking bench for stage_mm with hand-computed values.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stage_mm;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        in_flush;
    logic        in_reg_wr;
    logic [4:0]  in_reg_addr_rd;
    logic [31:0] in_reg_data_rd;
    logic [31:0] in_mem_addr;
    logic        in_is_load;
    logic        in_is_store;
    logic        stall;
    logic        misaligned;
    logic        out_reg_wr;
    logic [4:0]  out_reg_addr_rd;
    logic [31:0] out_reg_data_rd;
    logic        out_flush;

    int checks = 0;
    int errors = 0;

    stage_mm_if #(.DATA_W(32), .DATA_ADDR_W(32)) bus ();

    stage_mm #(.DATA_W(32), .DATA_ADDR_W(32), .REG_ADDR_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .in_flush        (in_flush),
        .in_reg_wr       (in_reg_wr),
        .in_reg_addr_rd  (in_reg_addr_rd),
        .in_reg_data_rd  (in_reg_data_rd),
        .in_mem_addr     (in_mem_addr),
        .in_is_load      (in_is_load),
        .in_is_store     (in_is_store),
        .mem             (bus),
        .stall           (stall),
        .misaligned      (misaligned),
        .out_reg_wr      (out_reg_wr),
        .out_reg_addr_rd (out_reg_addr_rd),
        .out_reg_data_rd (out_reg_data_rd),
        .out_flush       (out_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic fl, input logic wr, input logic [4:0] rd,
                          input logic [31:0] data, input logic [31:0] addr,
                          input logic ld, input logic st);
        in_flush       = fl;
        in_reg_wr      = wr;
        in_reg_addr_rd = rd;
        in_reg_data_rd = data;
        in_mem_addr    = addr;
        in_is_load     = ld;
        in_is_store    = st;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        set_op(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;

        // Reset state
        tick();
        chk("rst_out_flush", {31'b0, out_flush}, 32'h1);
        chk("rst_out_reg_wr", {31'b0, out_reg_wr}, 32'h0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'h0);
        chk("rst_out_rd", {27'b0, out_reg_addr_rd}, 32'h0);
        chk("rst_out_data", out_reg_data_rd, 32'h0);
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        rst_n = 1'b1;

        // Zero-wait load
        set_op(1'b0, 1'b1, 5'd5, 32'h0, 32'h100, 1'b1, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld0_req", {31'b0, bus.mem_req}, 32'h1);
        chk("ld0_addr", bus.mem_addr, 32'h100);
        chk("ld0_we", {31'b0, bus.mem_we}, 32'h0);
        chk("ld0_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("ld0_out_wr", {31'b0, out_reg_wr}, 32'h1);
        chk("ld0_out_rd", {27'b0, out_reg_addr_rd}, 32'h5);
        chk("ld0_out_data", out_reg_data_rd, 32'hDEADBEEF);
        chk("ld0_out_flush", {31'b0, out_flush}, 32'h0);

        // ALU pass-through
        set_op(1'b0, 1'b1, 5'd7, 32'h55, 32'h0, 1'b0, 1'b0);
        bus.mem_ack = 1'b0;
        #1;
        chk("alu_req", {31'b0, bus.mem_req}, 32'h0);
        chk("alu_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("alu_out_wr", {31'b0, out_reg_wr}, 32'h1);
        chk("alu_out_rd", {27'b0, out_reg_addr_rd}, 32'h7);
        chk("alu_out_data", out_reg_data_rd, 32'h55);

        // Stray ack in IDLE has no effect
        set_op(1'b0, 1'b1, 5'd8, 32'h66, 32'h0, 1'b0, 1'b0);
        bus.mem_ack = 1'b1;
        #1;
        chk("stray_ack_req", {31'b0, bus.mem_req}, 32'h0);
        chk("stray_ack_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("stray_ack_data", out_reg_data_rd, 32'h66);
        bus.mem_ack = 1'b0;

        // Store with 3 wait states; reg_wr set to prove store gating
        set_op(1'b0, 1'b1, 5'd2, 32'h12345678, 32'h204, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.mem_ack = (i == 3);
            #1;
            chk("st_req", {31'b0, bus.mem_req}, 32'h1);
            chk("st_we", {31'b0, bus.mem_we}, 32'h1);
            chk("st_addr", bus.mem_addr, 32'h204);
            chk("st_wdata", bus.mem_wdata, 32'h12345678);
            chk("st_stall", {31'b0, stall}, (i < 3) ? 32'h1 : 32'h0);
            tick();
            if (i < 3) begin
                chk("st_bubble_wr", {31'b0, out_reg_wr}, 32'h0);
                chk("st_bubble_flush", {31'b0, out_flush}, 32'h1);
            end
        end
        chk("st_done_wr", {31'b0, out_reg_wr}, 32'h0);
        chk("st_done_flush", {31'b0, out_flush}, 32'h0);
        bus.mem_ack = 1'b0;

        // Misaligned load
        set_op(1'b0, 1'b1, 5'd4, 32'h99, 32'h102, 1'b1, 1'b0);
        #1;
        chk("mis_req", {31'b0, bus.mem_req}, 32'h0);
        chk("mis_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("mis_pulse", {31'b0, misaligned}, 32'h1);
        chk("mis_out_wr", {31'b0, out_reg_wr}, 32'h0);
        set_op(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("mis_pulse_end", {31'b0, misaligned}, 32'h0);
        chk("mis_next_flush", {31'b0, out_flush}, 32'h1);

        // Flushed load, then a valid load with one wait state
        set_op(1'b1, 1'b1, 5'd6, 32'h0, 32'h100, 1'b1, 1'b0);
        #1;
        chk("fl_req", {31'b0, bus.mem_req}, 32'h0);
        tick();
        chk("fl_out_flush", {31'b0, out_flush}, 32'h1);
        chk("fl_out_wr", {31'b0, out_reg_wr}, 32'h0);
        set_op(1'b0, 1'b1, 5'd9, 32'h0, 32'h300, 1'b1, 1'b0);
        bus.mem_rdata = 32'hCAFEF00D;
        #1;
        chk("ld1_req", {31'b0, bus.mem_req}, 32'h1);
        chk("ld1_stall", {31'b0, stall}, 32'h1);
        tick();
        chk("ld1_wait_wr", {31'b0, out_reg_wr}, 32'h0);
        chk("ld1_wait_flush", {31'b0, out_flush}, 32'h1);
        bus.mem_ack = 1'b1;
        #1;
        chk("ld1_ack_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("ld1_out_wr", {31'b0, out_reg_wr}, 32'h1);
        chk("ld1_out_rd", {27'b0, out_reg_addr_rd}, 32'h9);
        chk("ld1_out_data", out_reg_data_rd, 32'hCAFEF00D);
        chk("ld1_out_flush", {31'b0, out_flush}, 32'h0);
        bus.mem_ack = 1'b0;

        // Async reset while waiting
        set_op(1'b0, 1'b1, 5'd10, 32'h0, 32'h400, 1'b1, 1'b0);
        tick();
        chk("wr_wait_stall", {31'b0, stall}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'b0, bus.mem_req}, 32'h0);
        chk("arst_flush", {31'b0, out_flush}, 32'h1);
        chk("arst_wr", {31'b0, out_reg_wr}, 32'h0);
        chk("arst_data", out_reg_data_rd, 32'h0);
        en    = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("arst_idle_req", {31'b0, bus.mem_req}, 32'h0);

        // en=0 holds outputs; en=1 then updates them
        set_op(1'b0, 1'b1, 5'd3, 32'h77, 32'h0, 1'b0, 1'b0);
        tick();
        chk("en0_hold_wr", {31'b0, out_reg_wr}, 32'h0);
        chk("en0_hold_flush", {31'b0, out_flush}, 32'h1);
        en = 1'b1;
        tick();
        chk("en1_out_wr", {31'b0, out_reg_wr}, 32'h1);
        chk("en1_out_data", out_reg_data_rd, 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
